// File: rtl/conv_layer_sequencer_if.sv
// Control/config bundle between the conv layer sequencer, its configuring host and the MAC datapath.
// master: sequencer side; slave: host/datapath side.
interface conv_layer_sequencer_if #(
    parameter int unsigned NUM_LAYERS = 5,
    parameter int unsigned MAX_CH     = 64,
    parameter int unsigned IMG_H      = 3,
    parameter int unsigned IMG_W      = 3,
    parameter int unsigned W_AW       = 16
);
    localparam int unsigned LW  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int unsigned CW  = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
    localparam int unsigned NW  = CW + 1;
    localparam int unsigned RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned CLW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic            start;
    logic            stall;
    logic            cfg_we;
    logic [LW-1:0]   cfg_layer;
    logic [NW-1:0]   cfg_cin;
    logic [NW-1:0]   cfg_cout;
    logic            busy;
    logic            done;
    logic [LW-1:0]   layer;
    logic [RW-1:0]   row;
    logic [CLW-1:0]  col;
    logic [CW-1:0]   oc;
    logic [CW-1:0]   ic;
    logic [1:0]      ki;
    logic [1:0]      kj;
    logic [W_AW-1:0] w_addr;
    logic            mac_en;
    logic            mac_clr;
    logic            bias_en;
    logic            wr_en;

    modport master (
        input  start, stall, cfg_we, cfg_layer, cfg_cin, cfg_cout,
        output busy, done, layer, row, col, oc, ic, ki, kj, w_addr,
        output mac_en, mac_clr, bias_en, wr_en
    );

    modport slave (
        output start, stall, cfg_we, cfg_layer, cfg_cin, cfg_cout,
        input  busy, done, layer, row, col, oc, ic, ki, kj, w_addr,
        input  mac_en, mac_clr, bias_en, wr_en
    );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Walks layer -> row -> col -> oc -> ic -> ki -> kj for the 3x3 conv MAC datapath,
// issuing indices and clear/accumulate/bias/write strobes with stall support.
module conv_layer_sequencer #(
    parameter int unsigned NUM_LAYERS = 5,
    parameter int unsigned MAX_CH     = 64,
    parameter int unsigned IMG_H      = 3,
    parameter int unsigned IMG_W      = 3,
    parameter int unsigned W_AW       = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    conv_layer_sequencer_if.master bus
);
    localparam int unsigned LW  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int unsigned CW  = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
    localparam int unsigned NW  = CW + 1;
    localparam int unsigned RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned CLW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StMac, StBias, StWrite, StDone} state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   layer_q, layer_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CLW-1:0]  col_q, col_d;
    logic [CW-1:0]   oc_q, oc_d;
    logic [CW-1:0]   ic_q, ic_d;
    logic [1:0]      ki_q, ki_d;
    logic [1:0]      kj_q, kj_d;
    logic [NW-1:0]   cin_q, cin_d;
    logic [NW-1:0]   cout_q, cout_d;
    logic [W_AW-1:0] w_addr_q, w_addr_d;

    logic [NW-1:0]   cin_tab_q  [NUM_LAYERS];
    logic [NW-1:0]   cout_tab_q [NUM_LAYERS];

    logic last_layer, last_ic, last_oc, last_col, last_row, cfg_ok;

    assign last_layer = (layer_q == LW'(NUM_LAYERS - 1));
    assign last_ic    = ({1'b0, ic_q} == cin_q - NW'(1));
    assign last_oc    = ({1'b0, oc_q} == cout_q - NW'(1));
    assign last_col   = (col_q == CLW'(IMG_W - 1));
    assign last_row   = (row_q == RW'(IMG_H - 1));
    assign cfg_ok     = bus.cfg_we && (state_q == StIdle || state_q == StDone) &&
                        (32'(bus.cfg_layer) < NUM_LAYERS);

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        row_d   = row_q;
        col_d   = col_q;
        oc_d    = oc_q;
        ic_d    = ic_q;
        ki_d    = ki_q;
        kj_d    = kj_q;
        cin_d   = cin_q;
        cout_d  = cout_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StLoad;
                    layer_d = '0;
                end
            end
            StLoad: begin
                cin_d  = cin_tab_q[layer_q];
                cout_d = cout_tab_q[layer_q];
                row_d  = '0;
                col_d  = '0;
                oc_d   = '0;
                ic_d   = '0;
                ki_d   = '0;
                kj_d   = '0;
                if (cout_d == '0) begin
                    if (last_layer) begin
                        state_d = StDone;
                    end else begin
                        layer_d = layer_q + LW'(1);
                    end
                end else if (cin_d == '0) begin
                    state_d = StBias;
                end else begin
                    state_d = StMac;
                end
            end
            StMac: begin
                if (!bus.stall) begin
                    // Indices stay on the final tap through BIAS/WRITE.
                    if (kj_q != 2'd2) begin
                        kj_d = kj_q + 2'd1;
                    end else if (ki_q != 2'd2) begin
                        kj_d = '0;
                        ki_d = ki_q + 2'd1;
                    end else if (!last_ic) begin
                        kj_d = '0;
                        ki_d = '0;
                        ic_d = ic_q + CW'(1);
                    end else begin
                        state_d = StBias;
                    end
                end
            end
            StBias: begin
                if (!bus.stall) state_d = StWrite;
            end
            StWrite: begin
                if (!bus.stall) begin
                    ic_d = '0;
                    ki_d = '0;
                    kj_d = '0;
                    state_d = (cin_q == '0) ? StBias : StMac;
                    if (!last_oc) begin
                        oc_d = oc_q + CW'(1);
                    end else begin
                        oc_d = '0;
                        if (!last_col) begin
                            col_d = col_q + CLW'(1);
                        end else begin
                            col_d = '0;
                            if (!last_row) begin
                                row_d = row_q + RW'(1);
                            end else begin
                                row_d = '0;
                                if (last_layer) begin
                                    state_d = StDone;
                                end else begin
                                    state_d = StLoad;
                                    layer_d = layer_q + LW'(1);
                                end
                            end
                        end
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign w_addr_d = W_AW'((32'(oc_d) * MAX_CH + 32'(ic_d)) * 32'd9 +
                            32'(ki_d) * 32'd3 + 32'(kj_d));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            layer_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            oc_q     <= '0;
            ic_q     <= '0;
            ki_q     <= '0;
            kj_q     <= '0;
            cin_q    <= '0;
            cout_q   <= '0;
            w_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            row_q    <= row_d;
            col_q    <= col_d;
            oc_q     <= oc_d;
            ic_q     <= ic_d;
            ki_q     <= ki_d;
            kj_q     <= kj_d;
            cin_q    <= cin_d;
            cout_q   <= cout_d;
            w_addr_q <= w_addr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                cin_tab_q[i]  <= '0;
                cout_tab_q[i] <= '0;
            end
        end else if (cfg_ok) begin
            cin_tab_q[bus.cfg_layer]  <= bus.cfg_cin;
            cout_tab_q[bus.cfg_layer] <= bus.cfg_cout;
        end
    end

    assign bus.busy    = (state_q == StLoad) || (state_q == StMac) ||
                         (state_q == StBias) || (state_q == StWrite);
    assign bus.done    = (state_q == StDone);
    assign bus.layer   = layer_q;
    assign bus.row     = row_q;
    assign bus.col     = col_q;
    assign bus.oc      = oc_q;
    assign bus.ic      = ic_q;
    assign bus.ki      = ki_q;
    assign bus.kj      = kj_q;
    assign bus.w_addr  = w_addr_q;
    assign bus.mac_en  = (state_q == StMac) && !bus.stall;
    assign bus.mac_clr = bus.mac_en && (ic_q == '0) && (ki_q == '0) && (kj_q == '0);
    assign bus.bias_en = (state_q == StBias) && !bus.stall;
    assign bus.wr_en   = (state_q == StWrite) && !bus.stall;
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: cycle-numbered runs with hand-computed
// cycle counts, strobe counts, address and ordering expectations.
module tb_conv_layer_sequencer;
    logic clk;
    logic rst_n;

    conv_layer_sequencer_if bus_if ();

    conv_layer_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int done_cyc, done_cnt, busy_c0, busy_c1, first_mac, n_mac, n_clr, n_bias, n_wr, n_busy;
    int bad_clr, bad_addr, bad_order, bad_stall, wr_idx, addr599, post_done;
    logic [44:0] rst_outs;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // {busy, done, mac_en, mac_clr, bias_en, wr_en, layer, row, col, oc, ic, ki, kj, w_addr}
    function automatic logic [44:0] outs();
        return {bus_if.busy, bus_if.done, bus_if.mac_en, bus_if.mac_clr, bus_if.bias_en,
                bus_if.wr_en, bus_if.layer, bus_if.row, bus_if.col, bus_if.oc, bus_if.ic,
                bus_if.ki, bus_if.kj, bus_if.w_addr};
    endfunction

    task automatic set_layer(input int l, input int cin, input int cout);
        @(negedge clk);
        bus_if.cfg_we    = 1'b1;
        bus_if.cfg_layer = 3'(l);
        bus_if.cfg_cin   = 7'(cin);
        bus_if.cfg_cout  = 7'(cout);
        @(negedge clk);
        bus_if.cfg_we    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Cycle 0 is the cycle with start high; outputs sampled on the falling edge.
    task automatic run_seq(input int exp_cout, input int stall_at, input int stall_len,
                           input int inj_at, input int rst_at, input int budget);
        int n;
        int pix;
        logic [44:0] cur;
        logic [44:0] snap;
        done_cyc = -1; done_cnt = 0; busy_c0 = -1; busy_c1 = -1; first_mac = -1;
        n_mac = 0; n_clr = 0; n_bias = 0; n_wr = 0; n_busy = 0;
        bad_clr = 0; bad_addr = 0; bad_order = 0; bad_stall = 0; wr_idx = 0;
        addr599 = -1; post_done = -1; rst_outs = '1; snap = '0;
        @(posedge clk);
        #1;
        bus_if.start = 1'b1;
        n = 0;
        @(negedge clk);
        busy_c0 = int'(bus_if.busy);
        while (n < budget) begin
            @(posedge clk);
            #1;
            n++;
            bus_if.start     = (n == inj_at);
            bus_if.cfg_we    = (n == inj_at);
            bus_if.cfg_layer = '0;
            bus_if.cfg_cin   = 7'd5;
            bus_if.cfg_cout  = 7'd5;
            bus_if.stall     = (stall_at >= 0 && n >= stall_at && n < stall_at + stall_len);
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                rst_outs = outs();
                break;
            end
            @(negedge clk);
            cur = outs();
            if (done_cyc >= 0) begin
                post_done = int'({bus_if.busy, bus_if.done});
                break;
            end
            if (n == 1) busy_c1 = int'(bus_if.busy);
            if (bus_if.done) begin
                done_cyc = n;
                done_cnt++;
            end
            n_busy += int'(bus_if.busy);
            n_mac  += int'(bus_if.mac_en);
            n_clr  += int'(bus_if.mac_clr);
            n_bias += int'(bus_if.bias_en);
            n_wr   += int'(bus_if.wr_en);
            if (bus_if.mac_en && first_mac < 0) first_mac = n;
            if (bus_if.mac_clr !== (bus_if.mac_en && bus_if.ic == 0 && bus_if.ki == 0 &&
                                    bus_if.kj == 0))
                bad_clr++;
            if (bus_if.mac_en && int'(bus_if.w_addr) != (int'(bus_if.oc) * 64 +
                int'(bus_if.ic)) * 9 + int'(bus_if.ki) * 3 + int'(bus_if.kj))
                bad_addr++;
            if (bus_if.mac_en && bus_if.oc == 1 && bus_if.ic == 2 && bus_if.ki == 1 &&
                bus_if.kj == 2)
                addr599 = int'(bus_if.w_addr);
            if (bus_if.wr_en) begin
                pix = wr_idx / exp_cout;
                if (int'(bus_if.row) != pix / 3 || int'(bus_if.col) != pix % 3 ||
                    int'(bus_if.oc) != wr_idx % exp_cout || bus_if.layer != 0)
                    bad_order++;
                wr_idx++;
            end
            if (stall_at >= 0) begin
                if (n == stall_at) snap = cur;
                if (n >= stall_at && n <= stall_at + stall_len && cur[38:0] != snap[38:0])
                    bad_stall++;
                if (n >= stall_at && n < stall_at + stall_len && cur[42:39] != 4'b0)
                    bad_stall++;
                if (n == stall_at + stall_len && !bus_if.mac_en) bad_stall++;
            end
        end
        bus_if.start  = 1'b0;
        bus_if.stall  = 1'b0;
        bus_if.cfg_we = 1'b0;
    endtask

    initial begin
        logic [44:0] o;
        rst_n            = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.stall     = 1'b0;
        bus_if.cfg_we    = 1'b0;
        bus_if.cfg_layer = '0;
        bus_if.cfg_cin   = '0;
        bus_if.cfg_cout  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        o = outs();
        check_eq("reset_outputs", longint'(o), 0);

        // Single 1x1-channel layer, four skipped layers
        set_layer(0, 1, 1);
        run_seq(1, -1, 0, -1, -1, 700);
        check_eq("s1_busy_c0", busy_c0, 0);
        check_eq("s1_busy_c1", busy_c1, 1);
        check_eq("s1_first_mac", first_mac, 2);
        check_eq("s1_mac_cnt", n_mac, 81);
        check_eq("s1_clr_cnt", n_clr, 9);
        check_eq("s1_bias_cnt", n_bias, 9);
        check_eq("s1_wr_cnt", n_wr, 9);
        check_eq("s1_wr_order", bad_order, 0);
        check_eq("s1_busy_cycles", n_busy, 104);
        check_eq("s1_done_cyc", done_cyc, 105);
        check_eq("s1_after_done", post_done, 0);

        // cin=3, cout=2: address arithmetic and clear qualification
        do_reset();
        set_layer(0, 3, 2);
        run_seq(2, -1, 0, -1, -1, 700);
        check_eq("s2_addr599", addr599, 599);
        check_eq("s2_addr_all", bad_addr, 0);
        check_eq("s2_clr_rule", bad_clr, 0);
        check_eq("s2_mac_cnt", n_mac, 486);
        check_eq("s2_clr_cnt", n_clr, 18);
        check_eq("s2_wr_order", bad_order, 0);
        check_eq("s2_done_cyc", done_cyc, 528);

        // Three-cycle stall in the middle of the third output's MAC
        do_reset();
        set_layer(0, 1, 1);
        run_seq(1, 27, 3, -1, -1, 700);
        check_eq("s3_stall_freeze", bad_stall, 0);
        check_eq("s3_mac_cnt", n_mac, 81);
        check_eq("s3_done_cyc", done_cyc, 108);

        // cin=0: bias-only outputs
        do_reset();
        set_layer(0, 0, 2);
        run_seq(2, -1, 0, -1, -1, 700);
        check_eq("s4_mac_cnt", n_mac, 0);
        check_eq("s4_bias_cnt", n_bias, 18);
        check_eq("s4_wr_cnt", n_wr, 18);
        check_eq("s4_wr_order", bad_order, 0);
        check_eq("s4_done_cyc", done_cyc, 42);

        // Every layer skipped
        do_reset();
        run_seq(1, -1, 0, -1, -1, 700);
        check_eq("s5_busy_cycles", n_busy, 5);
        check_eq("s5_strobes", n_mac + n_bias + n_wr, 0);
        check_eq("s5_done_cyc", done_cyc, 6);

        // start and table write while busy are both ignored
        do_reset();
        set_layer(0, 1, 1);
        run_seq(1, -1, 0, 20, -1, 700);
        check_eq("s6_done_cnt", done_cnt, 1);
        check_eq("s6_mac_cnt", n_mac, 81);
        check_eq("s6_done_cyc", done_cyc, 105);
        run_seq(1, -1, 0, -1, -1, 700);
        check_eq("s6_table_kept", done_cyc, 105);

        // Reset mid-run aborts at once and clears the table
        run_seq(1, -1, 0, -1, 50, 700);
        check_eq("s7_rst_outputs", longint'(rst_outs), 0);
        check_eq("s7_no_done", done_cnt, 0);
        @(negedge clk);
        o = outs();
        check_eq("s7_rst_held", longint'(o), 0);
        rst_n = 1'b1;
        run_seq(1, -1, 0, -1, -1, 700);
        check_eq("s7_table_cleared", done_cyc, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Control sequencer for the 3x3 convolution MAC datapath of the super-resolution CNN. It holds a per-layer channel-count table and walks layers, output pixels, output channels, input channels and kernel taps in a fixed nested order. For each step it issues weight/activation indices and clear/accumulate/bias/write strobes to the datapath, and it honours a stall from the datapath or memory side. Software loads the table, pulses `start` and waits for `done`.

## Interface
- `NUM_LAYERS`, default 5: number of conv layers in the table.
- `MAX_CH`, default 64: maximum channels per layer. This is the stride of the weight address.
- `IMG_H`, default 3: feature-map rows.
- `IMG_W`, default 3: feature-map columns.
- `W_AW`, default 16: weight address width. Must satisfy 2^W_AW ≥ MAX_CH*MAX_CH*9.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: run request, sampled in IDLE only.
- `stall` in 1: datapath back-pressure.
- `cfg_we` in 1: table write strobe.
- `cfg_layer` in clog2(NUM_LAYERS): table entry to write.
- `cfg_cin` in clog2(MAX_CH)+1: input-channel count, 0..MAX_CH.
- `cfg_cout` in clog2(MAX_CH)+1: output-channel count, 0..MAX_CH.
- `busy` out 1: high in LOAD, MAC, BIAS and WRITE.
- `done` out 1: one-cycle pulse at end of run.
- `layer` out clog2(NUM_LAYERS): current layer index.
- `row` out clog2(IMG_H), `col` out clog2(IMG_W): current output pixel.
- `oc` out clog2(MAX_CH): current output channel. This is also the bias index.
- `ic` out clog2(MAX_CH), `ki` out 2, `kj` out 2: current input channel and tap.
- `w_addr` out W_AW: weight address within the layer, (oc*MAX_CH+ic)*9 + ki*3 + kj.
- `mac_en` out 1: datapath performs acc += act[row+ki-1][col+kj-1][ic] * W[layer][w_addr].
- `mac_clr` out 1: qualifies `mac_en` on the first tap. On that tap the datapath loads the product instead of accumulating.
- `bias_en` out 1: datapath adds bias[layer][oc].
- `wr_en` out 1: datapath writes acc to out[row][col][oc].

## Operation
- Table:
  - NUM_LAYERS entries of {cin, cout}; reset value is 0/0 for every entry.
  - `cfg_we` writes the entry in IDLE or DONE. A write while `busy` is ignored.
  - An out-of-range `cfg_layer` is ignored.
- Loop order, outer to inner: layer → row → col → oc → ic → ki → kj. All counters start at 0.
- FSM states: IDLE, LOAD, MAC, BIAS, WRITE, DONE.
  - IDLE: `start`=1 → LOAD with layer=0. `start` in any other state is ignored.
  - LOAD: latches the layer's cin/cout and zeroes row, col, oc, ic, ki, kj.
    - cout=0: layer skipped. Go to LOAD of the next layer, or DONE if this is the last layer.
    - cin=0 (and cout≠0): go to BIAS.
    - Otherwise: go to MAC.
  - MAC: one tap per unstalled cycle; kj, then ki, then ic advance. After tap (ic=cin-1, ki=2, kj=2) → BIAS.
  - BIAS: 1 cycle, then WRITE.
  - WRITE: 1 cycle, then the next output in loop order.
    - Advance oc, then col, then row.
    - The next output goes to MAC, or to BIAS if cin=0.
    - After the last output of the layer → LOAD of the next layer, or DONE after the last layer.
  - DONE: `done`=1 for 1 cycle, then IDLE.
- Strobes:
  - `mac_en` = (state==MAC) & !stall.
  - `mac_clr` = `mac_en` & ic==0 & ki==0 & kj==0.
  - `bias_en` = (state==BIAS) & !stall.
  - `wr_en` = (state==WRITE) & !stall.
  - Strobes depend combinationally on `stall`. All other outputs are registered.
- Stall:
  - While `stall`=1 in MAC, BIAS or WRITE: state and every index are frozen and all strobes are low.
  - `stall` has no effect in IDLE, LOAD or DONE.
- Index outputs hold their last values in IDLE and DONE.
- Padding and edge handling are done by the datapath. The sequencer always emits ki/kj 0..2.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=IDLE.
  - `busy`, `done` and all strobes are 0.
  - All index outputs and `w_addr` are 0.
  - Table cleared.
  - Reset mid-run aborts immediately with no `done`.
- `start` sampled high at cycle 0 → LOAD and `busy`=1 at cycle 1. The first `mac_en` is at cycle 2.
- Cycle counts with no stall:
  - Each output takes 9*cin+2 cycles.
  - Each non-skipped layer takes 1 + IMG_H*IMG_W*cout*(9*cin+2) cycles.
  - Each skipped layer takes 1 cycle.
  - DONE follows the last layer by 1 cycle.
- Each stalled cycle extends the run by exactly one cycle.
- `w_addr` is valid in the same cycle as `mac_en`.

## Test plan
- Layer 0 {cin=1, cout=1}, layers 1-4 {0,0}, `start` at cycle 0:
  - LOAD at cycle 1; MAC/BIAS/WRITE over cycles 2-100, 9 outputs × 11 cycles.
  - 81 `mac_en`, 9 `mac_clr`, 9 `wr_en` with row/col visiting (0,0)..(2,2) row-major.
  - Skip LOADs at cycles 101-104; `done` at cycle 105.
- Layer 0 {3, 2}: at the `mac_en` with oc=1, ic=2, ki=1, kj=2 → `w_addr`=599. `mac_clr` only with ic=ki=kj=0.
- Same as the first scenario, with `stall`=1 for 3 cycles in mid-MAC → strobes low and indices frozen for those 3 cycles; `done` at cycle 108.
- Layer 0 {0, 2}, others skipped → no `mac_en`; 18 BIAS/WRITE pairs; `done` at cycle 1+1+36+4 = 42.
- All layers {0, 0} → 5 LOAD cycles, `done` at cycle 6, no strobes.
- During a run, pulse `start` and write `cfg_we` (layer 0 {5, 5}) → both ignored and the run is unchanged. Assert `rst_n`=0 at cycle 50 → all outputs 0 at once, IDLE, table cleared, no `done`.
